// File: rtl/mul_pkg.sv
// Shared constants for the 16x16 Wallace-tree multiplier.
// Also provides the row count left after each reduction layer.
package mul_pkg;

  localparam int unsigned MUL_W       = 16;
  localparam int unsigned PROD_W      = 32;
  localparam int unsigned TREE_LAYERS = 6;

  // Rows remaining after `layer` carry-save layers:
  // 3 rows become 2, and 1 or 2 leftover rows pass through.
  function automatic int unsigned rows_at(input int unsigned layer);
    int unsigned n;
    n = MUL_W;
    for (int unsigned k = 0; k < layer; k++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

endpackage

// File: rtl/wallace_fa.sv
// One-bit full adder: the carry-save cell used by every Wallace reduction layer.
module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/wallace_multiplier.sv
// Two-stage unsigned 16x16 -> 32 multiplier: registered operands, an explicit
// Wallace carry-save tree and a ripple carry-propagate adder, then a registered product.
module wallace_multiplier
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MUL_W-1:0]  ain,
  input  logic [MUL_W-1:0]  bin,
  output logic [PROD_W-1:0] p
);

  logic [MUL_W-1:0]  a_q, b_q;
  logic [PROD_W-1:0] p_q, p_d;
  logic [PROD_W-1:0] sum_a, sum_b;

  // lyr[0] holds the partial-product rows, lyr[L] the rows after layer L.
  for (genvar L = 0; L <= TREE_LAYERS; L++) begin : lyr
    localparam int unsigned NO = rows_at(L);
    logic [PROD_W-1:0] r [NO];

    if (L == 0) begin : g_pp
      for (genvar i = 0; i < MUL_W; i++) begin : g_row
        assign r[i] = {{(PROD_W-MUL_W){1'b0}}, a_q & {MUL_W{b_q[i]}}} << i;
      end
    end else begin : g_red
      localparam int unsigned NI = rows_at(L - 1);
      localparam int unsigned G  = NI / 3;

      for (genvar g = 0; g < G; g++) begin : g_csa
        logic [PROD_W-1:0] x, y, z, sm, cr;

        assign x = lyr[L-1].r[3*g];
        assign y = lyr[L-1].r[3*g+1];
        assign z = lyr[L-1].r[3*g+2];

        for (genvar b = 0; b < PROD_W - 1; b++) begin : g_bit
          wallace_fa u_fa (
            .a    (x[b]),
            .b    (y[b]),
            .cin  (z[b]),
            .s    (sm[b]),
            .cout (cr[b+1])
          );
        end

        // Carry out of the top bit is dropped: the tree works modulo 2^32,
        // which is exact because the full product always fits in 32 bits.
        assign sm[PROD_W-1] = x[PROD_W-1] ^ y[PROD_W-1] ^ z[PROD_W-1];
        assign cr[0]        = 1'b0;

        assign r[2*g]   = sm;
        assign r[2*g+1] = cr;
      end

      for (genvar k = 0; k < NI % 3; k++) begin : g_pass
        assign r[2*G+k] = lyr[L-1].r[3*G+k];
      end
    end
  end

  assign sum_a = lyr[TREE_LAYERS].r[0];
  assign sum_b = lyr[TREE_LAYERS].r[1];

  always_comb begin
    logic carry;
    carry = 1'b0;
    p_d   = '0;
    for (int unsigned i = 0; i < PROD_W; i++) begin
      p_d[i] = sum_a[i] ^ sum_b[i] ^ carry;
      carry  = (sum_a[i] & sum_b[i]) | (carry & (sum_a[i] ^ sum_b[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= ain;
      b_q <= bin;
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_wallace_multiplier.sv
// Self-checking bench for wallace_multiplier: directed vector table, reset
// sequences and random pairs, all checked through a 2-cycle scoreboard queue.
module tb_wallace_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ain = '0;
  logic [15:0] bin = '0;
  logic [31:0] p;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] exp_q  [$];
  string       name_q [$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  wallace_multiplier dut (
    .clk (clk),
    .rst (rst),
    .ain (ain),
    .bin (bin),
    .p   (p)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: p=%h expected %h", name, act, exp);
    end
  endtask

  // One cycle: at the falling edge, retire the result of inputs driven two
  // falling edges ago, then drive new operands and queue their expected product.
  task automatic cycle(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string name);
    @(negedge clk);
    if (exp_q.size() >= 2) check(p, exp_q.pop_front(), name_q.pop_front());
    ain = a;
    bin = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic restart_queue();
    exp_q.delete();
    name_q.delete();
    exp_q.push_back(32'h0);
    name_q.push_back("post_reset_0");
    exp_q.push_back(32'h0);
    name_q.push_back("post_reset_1");
  endtask

  initial begin
    logic [15:0] ra, rb;

    vecs.push_back('{16'h0020, 16'h0040, 32'h0000_0800, "basic_32x64"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "ffff_x_ffff"});
    vecs.push_back('{16'hFFFF, 16'h0001, 32'h0000_FFFF, "ffff_x_1"});
    vecs.push_back('{16'h8000, 16'h8000, 32'h4000_0000, "8000_x_8000"});
    vecs.push_back('{16'h0000, 16'hABCD, 32'h0000_0000, "0_x_abcd"});
    vecs.push_back('{16'h1234, 16'h5678, 32'h0626_0060, "pipe_1234x5678"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "pipe_ffffxffff"});
    vecs.push_back('{16'hAAAA, 16'h5555, 32'h38E3_1C72, "aaaa_x_5555"});
    vecs.push_back('{16'h0001, 16'h0001, 32'h0000_0001, "1_x_1"});

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check(p, 32'h0, "reset_async_initial");
    @(negedge clk);
    @(negedge clk);
    check(p, 32'h0, "reset_held");
    rst = 1'b0;
    restart_queue();

    // Lone product with zeros around it: nothing before the 2nd edge, then exact.
    cycle(16'h0020, 16'h0040, 32'h0000_0800, "basic_lone");
    cycle(16'h0000, 16'h0000, 32'h0, "basic_after_0");
    cycle(16'h0000, 16'h0000, 32'h0, "basic_after_1");

    foreach (vecs[i]) cycle(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    cycle(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "prefill_0");
    cycle(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "prefill_1");
    cycle(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "prefill_2");

    // Asynchronous reset mid-cycle while p holds FFFE0001.
    @(negedge clk);
    check(p, exp_q.pop_front(), name_q.pop_front());
    #2 rst = 1'b1;
    #1 check(p, 32'h0, "reset_async_midcycle");
    @(negedge clk);
    check(p, 32'h0, "reset_hold_ffff_inputs");
    ain = '0;
    bin = '0;
    rst = 1'b0;
    restart_queue();
    cycle(16'h0, 16'h0, 32'h0, "zero_0");
    cycle(16'h0, 16'h0, 32'h0, "zero_1");
    cycle(16'h0, 16'h0, 32'h0, "zero_2");

    // Reset while FFFF*FFFF is in the operand registers: it must never reach p.
    cycle(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "inflight_load");
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check(p, 32'h0, "reset_inflight");
    ain = '0;
    bin = '0;
    @(negedge clk);
    rst = 1'b0;
    restart_queue();
    for (int i = 0; i < 4; i++) cycle(16'h0, 16'h0, 32'h0, "inflight_discarded");

    // Random back-to-back pairs.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      cycle(ra, rb, {16'h0, ra} * {16'h0, rb}, "random");
    end
    cycle(16'h0, 16'h0, 32'h0, "drain_0");
    cycle(16'h0, 16'h0, 32'h0, "drain_1");
    cycle(16'h0, 16'h0, 32'h0, "drain_2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
